// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product binary-to-BCD converter: FSM encoding and
// the double-dabble digit adjustment constants.
package product_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Request/result bundle between the multiplier side and the BCD converter;
// the converter is the slave, its requester the master.
interface product_bcd_converter_if #(
    parameter int MAG_W  = 15,
    parameter int DIGITS = 5
);

    logic                  start;
    logic                  sign_in;
    logic [MAG_W-1:0]      mag_in;
    logic                  busy;
    logic                  valid;
    logic                  sign_out;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, sign_in, mag_in,
        input  busy, valid, sign_out, bcd, blank
    );

    modport slave (
        input  start, sign_in, mag_in,
        output busy, valid, sign_out, bcd, blank
    );

endinterface

// File: rtl/product_bcd_converter_bcd_digit_adj.sv
// One BCD digit's add-3 correction, applied ahead of each double-dabble shift.
module bcd_digit_adj
    import product_bcd_converter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] digit_adj
);

    assign digit_adj = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: one magnitude bit per clock, then the
// digits, zero-corrected sign and leading-zero blank mask are registered together.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int MAG_W  = 15,
    parameter int DIGITS = 5
)(
    input  logic                     clk,
    input  logic                     rst_n,
    product_bcd_converter_if.slave   bus
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(MAG_W + 1);

    if (10**DIGITS <= 2**MAG_W) begin : g_bad_params
        $error("product_bcd_converter: DIGITS too small to hold MAG_W-bit magnitude");
    end

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [MAG_W-1:0]    mag_sr;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_adj;
    logic                sign_cap;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (acc[4*i +: 4]),
            .digit_adj (acc_adj[4*i +: 4])
        );
    end

    // Blank bit i (i >= 1) is set when digit i and every digit above it are zero.
    function automatic logic [DIGITS-2:0] blank_upper(input logic [ACC_W-5:0] upper);
        logic [DIGITS-2:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_above = zero_above & (upper[4*i +: 4] == 4'd0);
            mask[i]    = zero_above;
        end
        return mask;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mag_sr       <= '0;
            acc          <= '0;
            sign_cap     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.sign_out <= 1'b0;
            bus.bcd      <= '0;
            bus.blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            case (state)
                IDLE: begin
                    bus.valid <= 1'b0;
                    if (bus.start) begin
                        state    <= SHIFT;
                        bus.busy <= 1'b1;
                        mag_sr   <= bus.mag_in;
                        sign_cap <= bus.sign_in;
                        acc      <= '0;
                        cnt      <= CNT_W'(MAG_W);
                    end
                end
                SHIFT: begin
                    acc    <= ACC_W'({acc_adj, mag_sr[MAG_W-1]});
                    mag_sr <= mag_sr << 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A zero result can only come from a zero magnitude, so it suppresses negative zero.
                    bus.bcd      <= acc;
                    bus.sign_out <= sign_cap & (acc != '0);
                    bus.blank    <= {blank_upper(acc[ACC_W-1:4]), 1'b0};
                    bus.valid    <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomised bench for product_bcd_converter with a decimal-arithmetic reference model.
module tb_product_bcd_converter;

    localparam int MAG_W  = 15;
    localparam int DIGITS = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    product_bcd_converter_if #(.MAG_W(MAG_W), .DIGITS(DIGITS)) bus ();

    product_bcd_converter #(.MAG_W(MAG_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int m);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int m);
        logic [4:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (m < p);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic logic ref_sign(input logic s, input int m);
        return s && (m != 0);
    endfunction

    // Issues one start, returns the result seen with valid and the edges from start to valid.
    task automatic run_conv(input logic s, input int m, input bit scramble,
                            output logic [19:0] got_bcd, output logic got_sign,
                            output logic [4:0] got_blank, output int lat, output bit hold_ok);
        logic [19:0] prev;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.sign_in = s;
        bus.mag_in  = 15'(m);
        prev        = bus.bcd;
        hold_ok     = 1'b1;
        lat         = -1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (scramble) begin
            bus.mag_in  = 15'($urandom);
            bus.sign_in = 1'($urandom);
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.bcd !== prev) hold_ok = 1'b0;
            if (scramble) begin
                bus.mag_in  = 15'($urandom);
                bus.sign_in = 1'($urandom);
            end
        end
        got_bcd   = bus.bcd;
        got_sign  = bus.sign_out;
        got_blank = bus.blank;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.sign_in = 1'b0;
        bus.mag_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.sign_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b valid=%b sign=%b exp 0/0/0", bus.busy, bus.valid, bus.sign_out);
        end
        checks++;
        if (bus.bcd !== 20'h0 || bus.blank !== 5'b11110) begin
            failures++;
            $display("FAIL reset_data got bcd=%h blank=%b exp 00000/11110", bus.bcd, bus.blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [19:0] b; logic s; logic [4:0] bl; int lat; bit hold;
        run_conv(1'b0, 16384, 1'b0, b, s, bl, lat, hold);
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL latency got=%0d exp=16", lat);
        end
        checks++;
        if (b !== 20'h16384 || s !== 1'b0 || bl !== 5'b00000) begin
            failures++;
            $display("FAIL conv_16384 got bcd=%h sign=%b blank=%b exp 16384/0/00000", b, s, bl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL valid_pulse got valid=%b busy=%b exp 0/0", bus.valid, bus.busy);
        end
    endtask

    task automatic test_spec_vectors();
        logic [19:0] b; logic s; logic [4:0] bl; int lat; bit hold;
        logic sv [3] = '{1'b1, 1'b1, 1'b0};
        int   mv [3] = '{0, 42, 32767};
        for (int k = 0; k < 3; k++) begin
            run_conv(sv[k], mv[k], 1'b0, b, s, bl, lat, hold);
            checks++;
            if (lat !== 16 || b !== ref_bcd(mv[k]) || s !== ref_sign(sv[k], mv[k]) || bl !== ref_blank(mv[k])) begin
                failures++;
                $display("FAIL vector_%0d got lat=%0d bcd=%h sign=%b blank=%b exp 16/%h/%b/%b", mv[k], lat, b, s, bl,
                         ref_bcd(mv[k]), ref_sign(sv[k], mv[k]), ref_blank(mv[k]));
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [19:0] b; logic s; logic [4:0] bl; int lat; bit hold;
        int a; int vcount; logic [19:0] vbcd;
        a      = $urandom_range(100, 32767);
        vcount = 0;
        vbcd   = '0;
        for (int e = 0; e <= 16; e++) begin
            @(negedge clk);
            bus.start   = (e == 0 || e == 5 || e == 16);
            bus.sign_in = 1'b0;
            bus.mag_in  = (e == 0) ? 15'(a) : 15'(99);
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                vcount++;
                vbcd = bus.bcd;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (vcount !== 1 || vbcd !== ref_bcd(a)) begin
            failures++;
            $display("FAIL busy_ignore got pulses=%0d bcd=%h exp 1/%h", vcount, vbcd, ref_bcd(a));
        end
        // This start lands at edge 17, the first edge back in IDLE.
        run_conv(1'b0, 99, 1'b0, b, s, bl, lat, hold);
        checks++;
        if (lat !== 16 || b !== 20'h00099 || bl !== 5'b11100) begin
            failures++;
            $display("FAIL restart_99 got lat=%0d bcd=%h blank=%b exp 16/00099/11100", lat, b, bl);
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] b; logic s; logic [4:0] bl; int lat; bit hold; int m; logic sg;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mag_in = 15'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_shift got=%b exp=1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.bcd !== 20'h0 || bus.blank !== 5'b11110
            || bus.sign_out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got busy=%b valid=%b bcd=%h blank=%b sign=%b exp 0/0/00000/11110/0",
                     bus.busy, bus.valid, bus.bcd, bus.blank, bus.sign_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m  = $urandom_range(1, 32767);
        sg = 1'b1;
        run_conv(sg, m, 1'b0, b, s, bl, lat, hold);
        checks++;
        if (lat !== 16 || b !== ref_bcd(m) || s !== ref_sign(sg, m) || bl !== ref_blank(m)) begin
            failures++;
            $display("FAIL post_reset got lat=%0d bcd=%h sign=%b blank=%b exp 16/%h/%b/%b", lat, b, s, bl,
                     ref_bcd(m), ref_sign(sg, m), ref_blank(m));
        end
    endtask

    task automatic test_input_capture();
        logic [19:0] b; logic s; logic [4:0] bl; int lat; bit hold; int m; logic sg;
        for (int k = 0; k < 4; k++) begin
            m  = (k == 0) ? 0 : $urandom_range(0, 32767);
            sg = 1'($urandom);
            run_conv(sg, m, 1'b1, b, s, bl, lat, hold);
            checks++;
            if (lat !== 16 || b !== ref_bcd(m) || s !== ref_sign(sg, m) || bl !== ref_blank(m)) begin
                failures++;
                $display("FAIL capture_%0d got lat=%0d bcd=%h sign=%b blank=%b exp 16/%h/%b/%b", m, lat, b, s, bl,
                         ref_bcd(m), ref_sign(sg, m), ref_blank(m));
            end
            checks++;
            if (hold !== 1'b1) begin
                failures++;
                $display("FAIL output_hold got changed=%b exp stable before valid", !hold);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [19:0] b; logic s; logic [4:0] bl; int lat; bit hold; int m; logic sg;
        int edge_vals [6] = '{1, 9, 10, 9999, 10000, 32767};
        for (int k = 0; k < 24; k++) begin
            m  = (k < 6) ? edge_vals[k] : $urandom_range(0, 32767);
            sg = 1'($urandom);
            run_conv(sg, m, 1'b0, b, s, bl, lat, hold);
            checks++;
            if (lat !== 16 || b !== ref_bcd(m) || s !== ref_sign(sg, m) || bl !== ref_blank(m)) begin
                failures++;
                $display("FAIL random_%0d got lat=%0d bcd=%h sign=%b blank=%b exp 16/%h/%b/%b", m, lat, b, s, bl,
                         ref_bcd(m), ref_sign(sg, m), ref_blank(m));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_latency();
        test_spec_vectors();
        test_start_while_busy();
        test_async_reset();
        test_input_capture();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
